// File: rtl/core_pkg.sv
// Shared RV32I encoding types: immediate-format codes and opcode constants.
// Used by the instruction encoder and the sign extender so both agree on the format codes.
// No logic here, only types and constants.
package core_pkg;

  // Immediate format selector; codes 110/111 are illegal
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_R = 3'b101
  } imm_src_t;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-in / word-out stream bundle between the field source, the encoder and the loader.
// Carries no state; timing is set by the modules on either side.
// in_valid/in_ready on the field side, out_valid/out_ready on the word side.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               imm_src;
  logic [6:0]               opcode;
  logic [4:0]               rd;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [2:0]               funct3;
  logic [6:0]               funct7;
  logic [31:0]              imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [ADDR_WIDTH-1:0]    out_addr;
  logic                     out_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  // field producer / word consumer side
  modport master (
    output in_valid, imm_src, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  // encoder side
  modport slave (
    input  in_valid, imm_src, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/instr_pack.sv
// Packs RV32I fields and an immediate into an instruction word and flags unencodable immediates.
// Purely combinational, zero latency.
// No handshake; the enclosing stage decides when the result is captured.
module instr_pack
  import core_pkg::*;
(
  input  logic [2:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Select the bit layout for the format; errored words still carry the truncated encoding
  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (imm_src_t'(imm_src))
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = (imm[31:11] != {21{imm[11]}});
      end
      IMM_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'h000);
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      IMM_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      default: begin
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32I fields into instruction words tagged with their instruction-memory byte address.
// One register stage: word appears the cycle after input fire, one word per cycle sustained.
// in_ready = !out_valid | out_ready; output word held stable while out_ready is low.
module instr_encoder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    ERR_CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  instr_encoder_if.slave bus
);

  logic        in_fire;
  logic        out_fire;
  logic [31:0] pack_instr;
  logic        pack_err;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;

  instr_pack u_pack (
    .imm_src (bus.imm_src),
    .opcode  (bus.opcode),
    .rd      (bus.rd),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .imm     (bus.imm),
    .instr   (pack_instr),
    .err     (pack_err)
  );

  // Output register: load on input fire, otherwise empty out once the word is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_err   <= 1'b0;
    end else if (in_fire) begin
      bus.out_valid <= 1'b1;
      bus.out_instr <= pack_instr;
      bus.out_err   <= pack_err;
    end else if (out_fire) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Address of the word in the register; clr wins over the post-fire advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_addr <= BASE_ADDR;
    end else if (clr) begin
      bus.out_addr <= BASE_ADDR;
    end else if (out_fire) begin
      bus.out_addr <= bus.out_addr + ADDR_WIDTH'(4);
    end
  end

  // Saturating count of delivered words that carried an error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.err_count <= '0;
    end else if (clr) begin
      bus.err_count <= '0;
    end else if (out_fire && bus.out_err && !(&bus.err_count)) begin
      bus.err_count <= bus.err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder with directed spot checks.
// Two instances share stimulus: base address 0 and base address FFFF_FFF8 (wrap).
// A negedge monitor checks every delivered word against a queue of expected results.
module tb_instr_encoder;
  import core_pkg::*;

  localparam logic [31:0] BASE_LO = 32'h0000_0000;
  localparam logic [31:0] BASE_HI = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  instr_encoder_if #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) bus ();
  instr_encoder_if #(.ADDR_WIDTH(32), .ERR_CNT_WIDTH(8)) bus_hi ();

  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(BASE_LO), .ERR_CNT_WIDTH(8)) u_dut (
    .clk (clk), .rst (rst), .clr (clr), .bus (bus)
  );
  instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(BASE_HI), .ERR_CNT_WIDTH(8)) u_dut_hi (
    .clk (clk), .rst (rst), .clr (clr), .bus (bus_hi)
  );

  assign bus_hi.in_valid  = bus.in_valid;
  assign bus_hi.imm_src   = bus.imm_src;
  assign bus_hi.opcode    = bus.opcode;
  assign bus_hi.rd        = bus.rd;
  assign bus_hi.rs1       = bus.rs1;
  assign bus_hi.rs2       = bus.rs2;
  assign bus_hi.funct3    = bus.funct3;
  assign bus_hi.funct7    = bus.funct7;
  assign bus_hi.imm       = bus.imm;
  assign bus_hi.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: format rules written as ranges and alignment
  function automatic exp_t model(input logic [2:0] src, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    exp_t e;
    int   s;
    s = int'($signed(imm));
    case (src)
      3'd0: begin e.instr = {imm[11:0], rs1, f3, rd, op}; e.err = (s < -2048) || (s > 2047); end
      3'd1: begin e.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; e.err = (s < -2048) || (s > 2047); end
      3'd2: begin
        e.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        e.err   = (s < -4096) || (s > 4095) || (imm % 32'd2 != 0);
      end
      3'd3: begin e.instr = {imm[31:12], rd, op}; e.err = (imm % 32'd4096) != 0; end
      3'd4: begin
        e.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        e.err   = (s < -(1 << 20)) || (s > (1 << 20) - 1) || (imm % 32'd2 != 0);
      end
      3'd5: begin e.instr = {f7, rs2, rs1, f3, rd, op}; e.err = 1'b0; end
      default: begin e.instr = 32'h0000_0013; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  exp_t cur_exp;
  exp_t q[$];
  exp_t q_hi[$];
  logic [31:0] exp_addr = BASE_LO;
  logic [31:0] exp_hi   = BASE_HI;
  int          exp_cnt  = 0;
  int          hi_idx   = 0;
  logic        stall_prev = 1'b0;
  logic        clr_prev   = 1'b0;
  logic [31:0] held_instr;
  logic [31:0] held_addr;
  logic [31:0] hi_tbl [3];
  initial begin
    hi_tbl[0] = 32'hFFFF_FFF8;
    hi_tbl[1] = 32'hFFFF_FFFC;
    hi_tbl[2] = 32'h0000_0000;
  end

  // Monitor: pop on output fire, push on input fire, advance address/counter model
  always @(negedge clk) begin
    exp_t e;
    logic fire;
    if (rst) begin
      q.delete();
      q_hi.delete();
      exp_addr   = BASE_LO;
      exp_hi     = BASE_HI;
      exp_cnt    = 0;
      hi_idx     = 0;
      stall_prev = 1'b0;
      clr_prev   = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (stall_prev && bus.out_valid) begin
        chk("stall_instr", bus.out_instr, held_instr);
        if (!clr_prev) chk("stall_addr", bus.out_addr, held_addr);
      end
      fire = bus.out_valid && bus.out_ready;
      e.err = 1'b0;
      if (fire) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_err", 32'(bus.out_err), 32'(e.err));
          chk("out_addr", bus.out_addr, exp_addr);
          chk("err_count", 32'(bus.err_count), 32'(exp_cnt));
        end
      end
      if (bus_hi.out_valid && bus_hi.out_ready) begin
        if (q_hi.size() == 0) begin
          chk("hi_unexpected_word", 32'(1), 32'(0));
        end else begin
          exp_t eh;
          eh = q_hi.pop_front();
          chk("hi_instr", bus_hi.out_instr, eh.instr);
          chk("hi_addr", bus_hi.out_addr, exp_hi);
          if (hi_idx < 3) chk("hi_wrap_addr", bus_hi.out_addr, hi_tbl[hi_idx]);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_instr = bus.out_instr;
      held_addr  = bus.out_addr;
      clr_prev   = clr;
      if (clr) begin
        exp_addr = BASE_LO;
        exp_hi   = BASE_HI;
        exp_cnt  = 0;
        hi_idx   = 0;
      end else if (fire) begin
        exp_addr = exp_addr + 32'd4;
        exp_hi   = exp_hi + 32'd4;
        hi_idx   = hi_idx + 1;
        if (e.err && exp_cnt < 255) exp_cnt = exp_cnt + 1;
      end
      if (bus.in_valid && bus.in_ready) q.push_back(cur_exp);
      if (bus.in_valid && bus_hi.in_ready) q_hi.push_back(cur_exp);
    end
  end

  bit rand_rdy = 1'b0;

  task automatic setf(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit use_gold, input logic [31:0] g_instr, input logic g_err);
    bus.imm_src = src; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
    cur_exp = model(src, op, rd, rs1, rs2, f3, f7, imm);
    if (use_gold) begin
      cur_exp.instr = g_instr;
      cur_exp.err   = g_err;
    end
  endtask

  // Hold in_valid until the word is accepted; called at posedge+1
  task automatic drive(output int fire_cyc);
    bit fired;
    fired = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200 && !fired; k++) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fired = bus.in_ready;
      @(posedge clk);
      #1;
    end
    fire_cyc = cyc;
    if (!fired) chk("accept_timeout", 32'(0), 32'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] src, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input bit use_gold, input logic [31:0] g_instr, input logic g_err,
                      output int fire_cyc);
    setf(src, op, rd, rs1, rs2, f3, f7, imm, use_gold, g_instr, g_err);
    drive(fire_cyc);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #1;
      done = (q.size() == 0) && !bus.out_valid;
    end
    if (!done) chk("drain_timeout", 32'(0), 32'(1));
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom_range(0, 4095)) - 2048;
      1: v = int'($urandom_range(0, 8191)) - 4096;
      2: v = int'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      3: v = int'($urandom << 12);
      default: v = int'($urandom);
    endcase
    return 32'(v);
  endfunction

  initial begin
    int fc, fc_j, fc_u;
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    setf(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'(0));
    chk("rst_out_addr", bus.out_addr, BASE_LO);
    chk("rst_hi_addr", bus_hi.out_addr, BASE_HI);
    chk("rst_err_count", 32'(bus.err_count), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));

    // Directed vectors
    send(3'd0, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 1'b0, fc);
    send(3'd2, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE00_0EE3, 1'b0, fc);
    setf(3'd2, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0, 1'b0);
    cur_exp.err = 1'b1;
    drive(fc);
    drain();
    chk("err_count_after_b3", 32'(bus.err_count), 32'(1));

    send(3'd4, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h0080_00EF, 1'b0, fc_j);
    send(3'd3, OPC_LUI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_5137, 1'b0, fc_u);
    chk("b2b_consecutive", 32'(fc_u - fc_j), 32'(1));

    setf(3'd0, OPC_OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0, 1'b0);
    cur_exp.err = 1'b1;
    drive(fc);
    send(3'd7, OPC_OP, 5'd5, 5'd6, 5'd7, 3'd1, 7'h20, 32'd0, 1'b1, 32'h0000_0013, 1'b1, fc);
    drain();

    // Backpressure: word held for 3 cycles while the next one waits
    bus.out_ready = 1'b0;
    send(3'd1, OPC_STORE, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, 32'hFFFF_FF80, 1'b0, 32'd0, 1'b0, fc);
    setf(3'd5, OPC_OP, 5'd11, 5'd12, 5'd13, 3'd5, 7'h20, 32'd0, 1'b0, 32'd0, 1'b0);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'(0));
    end
    bus.out_ready = 1'b1;
    drive(fc);
    drain();

    // Reset while a word is pending
    bus.out_ready = 1'b0;
    send(3'd0, OPC_OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0, 1'b0, fc);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("midrst_out_addr", bus.out_addr, BASE_LO);
    chk("midrst_hi_addr", bus_hi.out_addr, BASE_HI);
    chk("midrst_err_count", 32'(bus.err_count), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Random traffic with random backpressure, gaps and clr pulses
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), rand_imm(), 1'b0, 32'd0, 1'b0, fc);
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 40) == 0) begin
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
      end
    end
    rand_rdy = 1'b0;
    drain();

    // Error counter saturation
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 260; i++) begin
      send(3'd6, OPC_OP, 5'($urandom), 5'd0, 5'd0, 3'd0, 7'd0, $urandom, 1'b1,
           32'h0000_0013, 1'b1, fc);
    end
    drain();
    chk("err_count_saturated", 32'(bus.err_count), 32'(255));
    chk("queue_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
